// File: rtl/vx_dispatch_pkg.sv
// rtl/vx_dispatch_pkg.sv - shared unit indices and helpers for the dispatch queue
package vx_dispatch_pkg;

    typedef enum logic [2:0] {
        EX_ALU = 3'd0,
        EX_LSU = 3'd1,
        EX_CSR = 3'd2,
        EX_FPU = 3'd3,
        EX_GPU = 3'd4,
        EX_NOP = 3'd7
    } ex_type_e;

    // Ceiling log2; used for pointer and occupancy widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vx_dispatch_queue_if.sv
// rtl/vx_dispatch_queue_if.sv - issue-side and unit-side handshake bundle
interface vx_dispatch_queue_if #(
    parameter int NUM_UNITS = 5,
    parameter int DATAW     = 128,
    parameter int EXT_BITS  = 3
);
    logic                       in_valid;
    logic [EXT_BITS-1:0]        in_ex_type;
    logic [DATAW-1:0]           in_data;
    logic                       in_ready;
    logic [NUM_UNITS-1:0]       out_valid;
    logic [NUM_UNITS*DATAW-1:0] out_data;
    logic [NUM_UNITS-1:0]       out_ready;

    // Producer of instructions and consumer of unit heads (bench / pipeline side).
    modport master (
        output in_valid, in_ex_type, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The dispatch queue itself.
    modport slave (
        input  in_valid, in_ex_type, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/vx_dispatch_fifo.sv
// rtl/vx_dispatch_fifo.sv - one per-unit FIFO with registered count and head
module vx_dispatch_fifo
    import vx_dispatch_pkg::*;
#(
    parameter int DATAW = 128,
    parameter int DEPTH = 4,
    parameter int PTRW  = clog2(DEPTH),
    parameter int CNTW  = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [DATAW-1:0] head_data,
    output logic [CNTW-1:0]  count,
    output logic             full
);
    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid     = (count != '0);
    assign full      = (count == CNTW'(DEPTH));
    assign head_data = mem[rd_ptr];
    // Full check uses the registered count, so a same-cycle pop never frees a slot.
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && valid && !flush;

    // Pointer and count state; flush wipes the queue regardless of pending pops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is left unreset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vx_dispatch_queue.sv
// rtl/vx_dispatch_queue.sv - routes issued instructions into per-unit FIFOs
module vx_dispatch_queue
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_UNITS = 5,
    parameter int DATAW     = 128,
    parameter int DEPTH     = 4,
    parameter int EXT_BITS  = 3,
    parameter int CNTW      = clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    vx_dispatch_queue_if.slave        bus,
    output logic [NUM_UNITS*CNTW-1:0] occupancy,
    output logic [31:0]               perf_stalls
);
    logic [EXT_BITS-1:0]        sel;
    logic                       is_nop;
    logic                       sel_full;
    logic                       in_ready_w;
    logic                       accept;
    logic                       stall;
    logic [NUM_UNITS-1:0]       push;
    logic [NUM_UNITS-1:0]       unit_full;
    logic [NUM_UNITS-1:0]       unit_valid;
    logic [NUM_UNITS*DATAW-1:0] head_flat;

    assign sel = bus.in_ex_type;

    // Decode the target unit; anything past the last unit is a NOP.
    always_comb begin
        is_nop   = 1'b1;
        sel_full = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (sel == EXT_BITS'(u)) begin
                is_nop   = 1'b0;
                sel_full = unit_full[u];
            end
        end
    end

    // in_ready depends only on registered counts, never on out_ready.
    assign in_ready_w   = reset && !flush && (is_nop || !sel_full);
    assign bus.in_ready = in_ready_w;
    assign accept       = bus.in_valid && in_ready_w;
    assign stall        = bus.in_valid && !in_ready_w && !flush;

    // One-hot push to the selected unit; accepted NOPs push nothing.
    always_comb begin
        push = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            push[u] = accept && !is_nop && (sel == EXT_BITS'(u));
        end
    end

    // Saturating stall counter, deliberately untouched by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls <= '0;
        end else if (stall && (perf_stalls != 32'hFFFF_FFFF)) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        vx_dispatch_fifo #(
            .DATAW (DATAW),
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .push      (push[u]),
            .push_data (bus.in_data),
            .pop       (bus.out_ready[u]),
            .valid     (unit_valid[u]),
            .head_data (head_flat[u*DATAW +: DATAW]),
            .count     (occupancy[u*CNTW +: CNTW]),
            .full      (unit_full[u])
        );
    end

    assign bus.out_valid = unit_valid;
    assign bus.out_data  = head_flat;

endmodule

// File: doc/vx_dispatch_queue.md
Name: vx_dispatch_queue

Overview:
- Parametrised successor to the per-unit skid-buffered dispatch stage. Routes each issued instruction payload from the ibuffer/GPR read stage to one of NUM_UNITS execution-unit queues, selected by ex_type.
- Each unit gets a DEPTH-entry FIFO instead of a 2-entry skid buffer. Adds per-unit occupancy reporting, a synchronous flush, and a saturating stall counter.
- There is no combinational path from any out_ready to in_ready.

Parameters:
NUM_UNITS, 5, number of execution-unit output channels (>=2)
DATAW, 128, payload width per instruction in bits
DEPTH, 4, entries per unit queue; power of two, >=2
EXT_BITS, 3, width of in_ex_type; 2^EXT_BITS >= NUM_UNITS
CNTW, $clog2(DEPTH)+1, derived occupancy width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (asserted when 0)
flush  in  1  synchronous discard of all queued entries
in_valid  in  1  ibuffer has an instruction
in_ex_type  in  EXT_BITS  target unit index; values >= NUM_UNITS are NOPs
in_data  in  DATAW  packed instruction payload
in_ready  out  1  instruction accepted when in_valid && in_ready
out_valid  out  NUM_UNITS  per-unit head valid
out_data  out  NUM_UNITS*DATAW  per-unit head payload; unit u at [u*DATAW +: DATAW]
out_ready  in  NUM_UNITS  per-unit consumer ready
occupancy  out  NUM_UNITS*CNTW  registered entry count per unit
perf_stalls  out  32  cycles with in_valid && !in_ready && !flush

Behaviour:
- Reset (reset==0, asynchronous):
  - all pointers, counts, out_valid, occupancy and perf_stalls go to 0.
  - in_ready is 0 while reset is asserted.
  - Payload storage is not reset.
- Routing:
  - sel = in_ex_type.
  - push[u] = in_valid && in_ready && sel==u && !flush.
  - Exactly one queue is pushed per accepted instruction.
- in_ready:
  - If flush, in_ready = 0.
  - Else if sel >= NUM_UNITS (NOP), in_ready = 1.
  - Else in_ready = (count[sel] != DEPTH), using the registered count only.
  - A full queue refuses a push even if out_ready[sel] pops in the same cycle.
- NOP handling: an accepted NOP is consumed and dropped; no queue changes.
- Latency: an entry pushed in cycle T is visible on out_valid/out_data at T+1 at the earliest (registered output, no bypass).
- Ordering: strict FIFO per unit. There is no ordering guarantee across units.
- Pop: pop[u] = out_valid[u] && out_ready[u]; the head advances next cycle.
- Simultaneous push and pop on a non-full, non-empty queue: count is unchanged, both pointers advance.
- Push into an empty queue while its output is idle: out_valid rises next cycle.
- out_valid[u] = (count[u] != 0). out_data[u] holds the head entry and is stable while out_valid && !out_ready.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count[u] ranges 0..DEPTH.
- Flush:
  - In cycle T, all counts and pointers are cleared at the T edge, so out_valid=0 from T+1.
  - No push is accepted in cycle T.
  - Pops asserted in cycle T are ignored (entries are discarded anyway).
- perf_stalls increments by 1 per stall cycle, saturates at 0xFFFF_FFFF, and is not cleared by flush.
- occupancy mirrors the registered count[u].
- Reset asserted mid-transfer: all queued entries are lost. No output handshake completes in that cycle.

Decomposition:
- Shared package vx_dispatch_pkg:
  - EX_* unit index constants (ALU=0, LSU=1, CSR=2, FPU=3, GPU=4) and EX_NOP.
  - A clog2 helper function.
- Sub-module vx_dispatch_fifo (DATAW, DEPTH):
  - one queue with push/pop, count, registered head; instantiated NUM_UNITS times by generate.
  - Top level holds routing, in_ready mux, flush fan-out and the perf counter.

Test Plan:
- Reset then single push: in_ex_type=1, in_data=0xA5 at T -> out_valid=5'b00010 at T+1, out_data[1]=0xA5, occupancy[1]=1; out_ready[1]=1 -> occupancy 0 at T+2.
- Fill unit 0 with 4 entries (0..3), out_ready=0:
  - 5th push -> in_ready=0, perf_stalls increments each cycle.
  - Raise out_ready[0] in the same cycle -> push still refused that cycle and accepted the next.
  - Drain order must be 0,1,2,3.
- Head-of-line isolation: unit 2 full and stalled, then push to unit 4 -> in_ready=1, out_valid[4]=1 next cycle; occupancy[2] stays 4.
- Simultaneous push and pop, DEPTH=4, unit 3 at count 2: streaming 20 entries with out_ready[3]=1 -> count stays 2, data is in order, pointers wrap 5 times.
- NOP and flush:
  - in_ex_type=7 -> in_ready=1, no out_valid change.
  - flush with units 0 and 1 non-empty -> out_valid=0 next cycle, push in the flush cycle is dropped, perf_stalls is unchanged.
- Async reset mid-stream: drive reset=0 between clock edges with 3 entries queued -> out_valid=0 and occupancy=0 immediately, with no clock edge required.
